video_tint_palette: RTL and testbench



---
 rtl/video_tint_pkg.sv | 38 +++
 rtl/video_tint_palette_if.sv | 37 +++
 rtl/video_tint_scale.sv | 17 +
 rtl/video_tint_palette.sv | 145 ++++++++++++++
 tb/tb_video_tint_palette.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/video_tint_pkg.sv
// Shared definitions for the video tint palette colouriser.
//   DEFAULT_TINT_RGB8 : reset contents of the tint palette, 8 bits per channel
//   sl_mode_e         : scanline darkening modes applied on odd lines
//   sync_t            : sync/blank bundle carried down the pixel pipeline
//   rep8              : bit-replicates an intensity level to 8 bits
package video_tint_pkg;

  // white, green, amber, cyan; all further entries are white
  localparam logic [23:0] DEFAULT_TINT_RGB8 [16] = '{
    24'hFFFFFF, 24'h33FF33, 24'hFFCC00, 24'h40FFA6,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF
  };

  typedef enum logic [1:0] {SL_OFF, SL_75, SL_50, SL_25} sl_mode_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hblank;
    logic vblank;
  } sync_t;

  // Repeat the level's bit pattern MSB-first across 8 bits so that the
  // maximum level maps to FF and level 0 maps to 00 for any width.
  function automatic logic [7:0] rep8(input logic [3:0] lvl, input int bits);
    logic [7:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx = 2'(bits - 1 - (i % bits));
      r[7-i] = lvl[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/video_tint_palette_if.sv
// Pixel stream / palette port bundle of video_tint_palette.
//   slave  : the colouriser (takes pixels, syncs, tint/palette controls;
//            drives RGB, delayed syncs/blanks, line parity)
//   master : the machine core side driving the stream
interface video_tint_palette_if #(
  parameter int PIX_BITS  = 1,
  parameter int OUT_BITS  = 6,
  parameter int NUM_TINTS = 4
);
  localparam int TW = $clog2(NUM_TINTS);

  logic                  ce_pix;
  logic [PIX_BITS-1:0]   pix_in;
  logic                  hs_in, vs_in, hblank_in, vblank_in;
  logic [TW-1:0]         tint_sel;
  logic [1:0]            scanlines;
  logic                  pal_wr;
  logic [TW-1:0]         pal_addr;
  logic [3*OUT_BITS-1:0] pal_data;
  logic [OUT_BITS-1:0]   r_out, g_out, b_out;
  logic                  hs_out, vs_out, hblank_out, vblank_out;
  logic                  line_odd;

  modport slave (
    input  ce_pix, pix_in, hs_in, vs_in, hblank_in, vblank_in,
           tint_sel, scanlines, pal_wr, pal_addr, pal_data,
    output r_out, g_out, b_out, hs_out, vs_out, hblank_out, vblank_out,
           line_odd
  );

  modport master (
    output ce_pix, pix_in, hs_in, vs_in, hblank_in, vblank_in,
           tint_sel, scanlines, pal_wr, pal_addr, pal_data,
    input  r_out, g_out, b_out, hs_out, vs_out, hblank_out, vblank_out,
           line_odd
  );
endinterface

// File: rtl/video_tint_scale.sv
// One colour channel of the intensity scaler: scaled = (base * (lrep+1)) >> 8.
//   base   : palette channel value
//   lrep   : intensity level replicated to 8 bits
//   scaled : base scaled by intensity (level 0 -> 0, full level -> base)
module video_tint_scale #(
  parameter int OUT_BITS = 6
) (
  input  logic [OUT_BITS-1:0] base,
  input  logic [7:0]          lrep,
  output logic [OUT_BITS-1:0] scaled
);
  // base <= 255 and lrep+1 <= 256, so 16 bits hold the product
  logic [15:0] prod;

  assign prod   = 16'(base) * (16'(lrep) + 16'd1);
  assign scaled = OUT_BITS'(prod >> 8);
endmodule

// File: rtl/video_tint_palette.sv
// Mono-to-RGB pixel colouriser with writable tint palette, frame-latched
// tint selection and odd-line scanline darkening.
//   clk_sys    : system clock
//   reset_in_n : asynchronous active-low reset
//   vif        : pixel stream, syncs, tint/palette controls in; RGB,
//                delayed syncs/blanks and undelayed line parity out
// Three ce_pix-gated stages: palette read, intensity scale, shade/blank.
module video_tint_palette
  import video_tint_pkg::*;
#(
  parameter int PIX_BITS  = 1,
  parameter int OUT_BITS  = 6,
  parameter int NUM_TINTS = 4
) (
  input logic clk_sys,
  input logic reset_in_n,
  video_tint_palette_if.slave vif
);
  localparam int TW = $clog2(NUM_TINTS);
  typedef logic [2:0][OUT_BITS-1:0] rgb_t;  // [2]=R [1]=G [0]=B

  function automatic rgb_t dflt(input int i);
    logic [23:0] d;
    d = DEFAULT_TINT_RGB8[i];
    return {d[23 -: OUT_BITS], d[15 -: OUT_BITS], d[7 -: OUT_BITS]};
  endfunction

  // palette: writes are not gated by ce_pix
  rgb_t pal [NUM_TINTS];

  always_ff @(posedge clk_sys or negedge reset_in_n) begin
    if (!reset_in_n) begin
      for (int i = 0; i < NUM_TINTS; i++) pal[i] <= dflt(i);
    end else if (vif.pal_wr) begin
      for (int i = 0; i < NUM_TINTS; i++)
        if (vif.pal_addr == TW'(i)) pal[i] <= vif.pal_data;
    end
  end

  // tint request, out-of-range entries fall back to 0
  logic [TW-1:0] tint_req;
  if ((1 << TW) == NUM_TINTS) begin : g_pow2
    assign tint_req = vif.tint_sel;
  end else begin : g_clip
    assign tint_req = (vif.tint_sel < TW'(NUM_TINTS)) ? vif.tint_sel : '0;
  end

  // sync edge detection runs every clock
  logic          hs_q, vs_q, line_odd;
  logic          hs_rise, vs_rise;
  logic [TW-1:0] tint_act;

  assign hs_rise = vif.hs_in & ~hs_q;
  assign vs_rise = vif.vs_in & ~vs_q;

  always_ff @(posedge clk_sys or negedge reset_in_n) begin
    if (!reset_in_n) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      line_odd <= 1'b0;
      tint_act <= '0;
    end else begin
      hs_q <= vif.hs_in;
      vs_q <= vif.vs_in;
      if (vs_rise) begin      // frame start wins over a coincident line start
        line_odd <= 1'b0;
        tint_act <= tint_req;
      end else if (hs_rise) begin
        line_odd <= ~line_odd;
      end
    end
  end

  assign vif.line_odd = line_odd;

  // pipeline
  logic [PIX_BITS-1:0] s1_pix;
  rgb_t                s1_base, s2_rgb, s3_rgb, scaled, shade;
  sync_t               s1_sync, s2_sync, s3_sync;
  logic                s1_odd, s2_odd;
  sl_mode_e            s1_sl, s2_sl;
  logic [7:0]          lrep;

  assign lrep = rep8(4'(s1_pix), PIX_BITS);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    video_tint_scale #(.OUT_BITS(OUT_BITS)) u_scale (
      .base  (s1_base[c]),
      .lrep  (lrep),
      .scaled(scaled[c])
    );
  end

  always_comb begin
    shade = s2_rgb;
    if (s2_odd) begin
      for (int c = 0; c < 3; c++) begin
        case (s2_sl)
          SL_75:   shade[c] = s2_rgb[c] - (s2_rgb[c] >> 2);
          SL_50:   shade[c] = s2_rgb[c] >> 1;
          SL_25:   shade[c] = s2_rgb[c] >> 2;
          default: shade[c] = s2_rgb[c];
        endcase
      end
    end
    if (s2_sync.hblank || s2_sync.vblank) shade = '0;
  end

  always_ff @(posedge clk_sys or negedge reset_in_n) begin
    if (!reset_in_n) begin
      s1_pix  <= '0;
      s1_base <= '0;
      s1_sync <= '0;
      s1_odd  <= 1'b0;
      s1_sl   <= SL_OFF;
      s2_rgb  <= '0;
      s2_sync <= '0;
      s2_odd  <= 1'b0;
      s2_sl   <= SL_OFF;
      s3_rgb  <= '0;
      s3_sync <= '0;
    end else if (vif.ce_pix) begin
      s1_pix  <= vif.pix_in;
      s1_base <= pal[tint_act];
      s1_sync <= '{hs: vif.hs_in, vs: vif.vs_in,
                   hblank: vif.hblank_in, vblank: vif.vblank_in};
      s1_odd  <= line_odd;
      s1_sl   <= sl_mode_e'(vif.scanlines);  // mode travels with its pixel
      s2_rgb  <= scaled;
      s2_sync <= s1_sync;
      s2_odd  <= s1_odd;
      s2_sl   <= s1_sl;
      s3_rgb  <= shade;
      s3_sync <= s2_sync;
    end
  end

  assign vif.r_out      = s3_rgb[2];
  assign vif.g_out      = s3_rgb[1];
  assign vif.b_out      = s3_rgb[0];
  assign vif.hs_out     = s3_sync.hs;
  assign vif.vs_out     = s3_sync.vs;
  assign vif.hblank_out = s3_sync.hblank;
  assign vif.vblank_out = s3_sync.vblank;
endmodule

// File: tb/tb_video_tint_palette.sv
// Directed bench for video_tint_palette: default build (1-bit pixels, 4 tints)
// plus a 2-bit / 3-tint build for intensity levels and tint clipping.
module tb_video_tint_palette;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_tint_palette_if #(.PIX_BITS(1), .OUT_BITS(6), .NUM_TINTS(4)) vif();
  video_tint_palette_if #(.PIX_BITS(2), .OUT_BITS(6), .NUM_TINTS(3)) vif2();

  video_tint_palette #(.PIX_BITS(1), .OUT_BITS(6), .NUM_TINTS(4)) u_dut (
    .clk_sys(clk), .reset_in_n(rst_n), .vif(vif));
  video_tint_palette #(.PIX_BITS(2), .OUT_BITS(6), .NUM_TINTS(3)) u_dut2 (
    .clk_sys(clk), .reset_in_n(rst_n), .vif(vif2));

  int total = 0;
  int passed = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_rgb(input string tag, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    check({tag, ".r"}, 32'(vif.r_out), 32'(r));
    check({tag, ".g"}, 32'(vif.g_out), 32'(g));
    check({tag, ".b"}, 32'(vif.b_out), 32'(b));
  endtask

  task automatic chk_rgb2(input string tag, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    check({tag, ".r"}, 32'(vif2.r_out), 32'(r));
    check({tag, ".g"}, 32'(vif2.g_out), 32'(g));
    check({tag, ".b"}, 32'(vif2.b_out), 32'(b));
  endtask

  task automatic vs_pulse();
    vif.vs_in = 1'b1; step();
    vif.vs_in = 1'b0; step();
  endtask

  task automatic hs_pulse();
    vif.hs_in = 1'b1; step();
    vif.hs_in = 1'b0; step();
  endtask

  initial begin
    vif.ce_pix = 1'b1; vif.pix_in = 1'b1; vif.hs_in = 1'b1; vif.vs_in = 1'b1;
    vif.hblank_in = 1'b0; vif.vblank_in = 1'b0; vif.tint_sel = '0;
    vif.scanlines = 2'd0; vif.pal_wr = 1'b0; vif.pal_addr = '0; vif.pal_data = '0;
    vif2.ce_pix = 1'b1; vif2.pix_in = '0; vif2.hs_in = 1'b0; vif2.vs_in = 1'b0;
    vif2.hblank_in = 1'b0; vif2.vblank_in = 1'b0; vif2.tint_sel = '0;
    vif2.scanlines = 2'd0; vif2.pal_wr = 1'b0; vif2.pal_addr = '0; vif2.pal_data = '0;

    // reset holds everything at zero
    step(3);
    chk_rgb("rst", 6'h00, 6'h00, 6'h00);
    check("rst.hs_out", 32'(vif.hs_out), 0);
    check("rst.vs_out", 32'(vif.vs_out), 0);
    check("rst.line_odd", 32'(vif.line_odd), 0);

    // first pixel after release: 3 ce_pix pulses of latency
    rst_n = 1'b1; vif.hs_in = 1'b0; vif.vs_in = 1'b0;
    step(2);
    chk_rgb("lat2", 6'h00, 6'h00, 6'h00);
    step(1);
    chk_rgb("lat3", 6'h3F, 6'h3F, 6'h3F);

    // tint change waits for frame start
    vif.tint_sel = 2'd1;
    step(5);
    chk_rgb("tint_mid", 6'h3F, 6'h3F, 6'h3F);
    vs_pulse(); step(3);
    chk_rgb("tint_green", 6'h0C, 6'h3F, 6'h0C);
    vif.tint_sel = 2'd0;
    vs_pulse(); step(3);
    chk_rgb("tint_white", 6'h3F, 6'h3F, 6'h3F);

    // scanlines on odd lines
    vif.scanlines = 2'd2;
    hs_pulse(); step(3);
    check("sl50.odd", 32'(vif.line_odd), 1);
    chk_rgb("sl50", 6'h1F, 6'h1F, 6'h1F);
    hs_pulse(); step(3);
    check("even.odd", 32'(vif.line_odd), 0);
    check("even.r", 32'(vif.r_out), 32'h3F);
    vif.scanlines = 2'd1;
    hs_pulse(); step(3);
    check("sl75.r", 32'(vif.r_out), 32'h30);
    vif.scanlines = 2'd3;
    step(4);
    check("sl25.r", 32'(vif.r_out), 32'h0F);

    // coincident hs/vs edges: frame start clears parity
    vif.hs_in = 1'b1; vif.vs_in = 1'b1; step();
    vif.hs_in = 1'b0; vif.vs_in = 1'b0; step();
    check("hsvs.odd", 32'(vif.line_odd), 0);
    step(3);
    check("hsvs.r", 32'(vif.r_out), 32'h3F);
    vif.scanlines = 2'd0;

    // palette write while ce_pix is low
    vif.ce_pix = 1'b0; vif.pal_wr = 1'b1; vif.pal_addr = 2'd0;
    vif.pal_data = {6'h3F, 6'h00, 6'h00};
    step();
    vif.pal_wr = 1'b0; vif.pal_data = '0;
    check("pal.hold_r", 32'(vif.g_out), 32'h3F);
    vif.ce_pix = 1'b1;
    step(4);
    chk_rgb("pal_red", 6'h3F, 6'h00, 6'h00);

    // hblank with ce_pix toggling: latency counts pulses only
    vif.hblank_in = 1'b1;
    vif.ce_pix = 1'b1; step();
    vif.ce_pix = 1'b0; step();
    check("hb.p1", 32'(vif.hblank_out), 0);
    step(2);
    check("hb.hold_r", 32'(vif.r_out), 32'h3F);
    vif.ce_pix = 1'b1; step();
    vif.ce_pix = 1'b0; step();
    check("hb.p2", 32'(vif.hblank_out), 0);
    vif.ce_pix = 1'b1; step();
    check("hb.p3", 32'(vif.hblank_out), 1);
    check("hb.r", 32'(vif.r_out), 0);
    vif.hblank_in = 1'b0;
    step(3);
    check("hb.off", 32'(vif.hblank_out), 0);
    check("hb.off_r", 32'(vif.r_out), 32'h3F);
    vif.vblank_in = 1'b1;
    step(3);
    check("vb.out", 32'(vif.vblank_out), 1);
    check("vb.r", 32'(vif.r_out), 0);
    vif.vblank_in = 1'b0;
    step(3);

    // 2-bit intensity, amber tint, out-of-range tint
    vif2.tint_sel = 2'd2;
    vif2.vs_in = 1'b1; step();
    vif2.vs_in = 1'b0; vif2.pix_in = 2'd3; step(3);
    chk_rgb2("amber_l3", 6'h3F, 6'h33, 6'h00);
    vif2.pix_in = 2'd0; step(3);
    chk_rgb2("amber_l0", 6'h00, 6'h00, 6'h00);
    vif2.pix_in = 2'd1; step(3);
    check("l1.r", 32'(vif2.r_out), 32'h15);
    vif2.pix_in = 2'd2; step(3);
    check("l2.r", 32'(vif2.r_out), 32'h2A);
    vif2.tint_sel = 2'd3;
    vif2.vs_in = 1'b1; step();
    vif2.vs_in = 1'b0; vif2.pix_in = 2'd3; step(3);
    chk_rgb2("tint_oor", 6'h3F, 6'h3F, 6'h3F);

    // reset mid-frame: immediate clear, palette defaults restored
    vif.scanlines = 2'd1;
    hs_pulse();
    rst_n = 1'b0; #1;
    check("mrst.r", 32'(vif.r_out), 0);
    check("mrst.odd", 32'(vif.line_odd), 0);
    step();
    rst_n = 1'b1; vif.scanlines = 2'd0;
    step(3);
    chk_rgb("mrst_dflt", 6'h3F, 6'h3F, 6'h3F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
